// File: rtl/mealy_scan_pkg.sv
// Shared types and match functions for the word-to-serial Mealy scan controller.
// The match functions are the single definition of both patterns.
package mealy_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int HIST_W = 3;

    // Pattern 0: a one preceded by zeros two and three bits back.
    function automatic logic match0(input logic b, input logic h1, input logic h2, input logic h3);
        return b & ~h2 & ~h3;
    endfunction

    // Pattern 1: a one preceded by ones one and three bits back.
    function automatic logic match1(input logic b, input logic h1, input logic h2, input logic h3);
        return b & h1 & h3;
    endfunction

endpackage

// File: rtl/mealy_scan_ctrl_if.sv
// Word-in / result-out handshake bundle between the scan controller and its
// producer/consumer.
interface mealy_scan_ctrl_if #(
    parameter int WIDTH = 10
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word;
    logic             abort;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_hits0;
    logic [WIDTH-1:0] out_hits1;
    logic [CNT_W-1:0] out_cnt0;
    logic [CNT_W-1:0] out_cnt1;

    modport master (
        output in_valid, in_word, abort, out_ready,
        input  in_ready, busy, out_valid, out_hits0, out_hits1, out_cnt0, out_cnt1
    );

    modport slave (
        input  in_valid, in_word, abort, out_ready,
        output in_ready, busy, out_valid, out_hits0, out_hits1, out_cnt0, out_cnt1
    );

endinterface

// File: rtl/mealy_scan_ctrl_detector.sv
// Bit-serial Mealy detector: a 3-bit history shift register, with the match
// outputs decoded combinationally from the current bit and that history.
module mealy_bit_detector
    import mealy_scan_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       i,
    output logic [1:0] o
);

    // r_hist[0] is the previous bit, r_hist[2] the bit three back.
    logic [HIST_W-1:0] r_hist;
    logic [HIST_W-1:0] w_hist_next;

    genvar gi;
    generate
        for (gi = 0; gi < HIST_W; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign w_hist_next[gi] = i;
            end else begin : g_tail
                assign w_hist_next[gi] = r_hist[gi-1];
            end

            always_ff @(posedge clock) begin
                if (reset || clear) begin
                    r_hist[gi] <= 1'b0;
                end else if (en) begin
                    r_hist[gi] <= w_hist_next[gi];
                end
            end
        end
    endgenerate

    assign o[0] = match0(i, r_hist[0], r_hist[1], r_hist[2]);
    assign o[1] = match1(i, r_hist[0], r_hist[1], r_hist[2]);

endmodule

// File: rtl/mealy_scan_ctrl.sv
// Accepts a parallel word, shifts it LSB-first through one Mealy detector and
// returns per-bit hit vectors and hit counts for both patterns.
module mealy_scan_ctrl
    import mealy_scan_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic              clock,
    input  logic              reset,
    mealy_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int IDX_W = $clog2(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_hits0;
    logic [WIDTH-1:0] r_hits1;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic [IDX_W-1:0] r_bit_idx;

    logic       w_accept;
    logic       w_abort;
    logic       w_shift_en;
    logic       w_clear;
    logic       w_bit;
    logic       w_last;
    logic [1:0] w_match;

    assign w_accept   = (r_state == IDLE) && bus.in_valid;
    assign w_abort    = (r_state == SHIFT) && bus.abort;
    assign w_shift_en = (r_state == SHIFT) && !bus.abort;
    // History is wiped both when a new word starts and when a scan is dropped.
    assign w_clear    = w_accept || w_abort;
    assign w_bit      = r_word[r_bit_idx];
    assign w_last     = (r_bit_idx == IDX_W'(WIDTH - 1));

    mealy_bit_detector u_det (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .en    (w_shift_en),
        .i     (w_bit),
        .o     (w_match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_hits0   <= '0;
            r_hits1   <= '0;
            r_cnt0    <= '0;
            r_cnt1    <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_word    <= bus.in_word;
                        r_hits0   <= '0;
                        r_hits1   <= '0;
                        r_cnt0    <= '0;
                        r_cnt1    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        r_hits0   <= '0;
                        r_hits1   <= '0;
                        r_cnt0    <= '0;
                        r_cnt1    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_hits0[r_bit_idx] <= w_match[0];
                        r_hits1[r_bit_idx] <= w_match[1];
                        r_cnt0             <= r_cnt0 + CNT_W'(w_match[0]);
                        r_cnt1             <= r_cnt1 + CNT_W'(w_match[1]);
                        if (w_last) begin
                            r_state <= DONE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Handshake flags come straight off the state register, so no input
    // reaches an output combinationally.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state == SHIFT);
    assign bus.out_valid = (r_state == DONE);
    assign bus.out_hits0 = r_hits0;
    assign bus.out_hits1 = r_hits1;
    assign bus.out_cnt0  = r_cnt0;
    assign bus.out_cnt1  = r_cnt1;

endmodule

// File: tb/tb_mealy_scan_ctrl.sv
// Directed bench for mealy_scan_ctrl: fixed words with hand-derived hit
// vectors, backpressure, abort and mid-scan reset.
module tb_mealy_scan_ctrl;

    localparam int WIDTH = 10;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    mealy_scan_ctrl_if #(.WIDTH(WIDTH)) bus ();

    mealy_scan_ctrl #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic chk_idle_clean(input string tag);
        chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
        chk({tag, ".busy"},      32'(bus.busy),      32'd0);
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".hits0"},     32'(bus.out_hits0), 32'd0);
        chk({tag, ".hits1"},     32'(bus.out_hits1), 32'd0);
        chk({tag, ".cnt0"},      32'(bus.out_cnt0),  32'd0);
        chk({tag, ".cnt1"},      32'(bus.out_cnt1),  32'd0);
    endtask

    task automatic scan(input string name, input logic [9:0] word,
                        input logic [9:0] e_h0, input logic [9:0] e_h1,
                        input logic [3:0] e_c0, input logic [3:0] e_c1);
        bus.in_word  = word;
        bus.in_valid = 1'b1;
        chk({name, ".ready_before"}, 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        chk({name, ".busy_t"},     32'(bus.busy),      32'd1);
        chk({name, ".in_ready_t"}, 32'(bus.in_ready),  32'd0);
        step(WIDTH - 1);
        chk({name, ".valid_early"}, 32'(bus.out_valid), 32'd0);
        chk({name, ".busy_last"},   32'(bus.busy),      32'd1);
        step();
        chk({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, ".busy_done"}, 32'(bus.busy),      32'd0);
        chk({name, ".hits0"},     32'(bus.out_hits0), 32'(e_h0));
        chk({name, ".hits1"},     32'(bus.out_hits1), 32'(e_h1));
        chk({name, ".cnt0"},      32'(bus.out_cnt0),  32'(e_c0));
        chk({name, ".cnt1"},      32'(bus.out_cnt1),  32'(e_c1));
        $display("scan %s word=0x%03h hits0=0x%03h hits1=0x%03h cnt0=%0d cnt1=%0d",
                 name, word, bus.out_hits0, bus.out_hits1, bus.out_cnt0, bus.out_cnt1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk({name, ".valid_drop"}, 32'(bus.out_valid), 32'd0);
        chk({name, ".ready_back"}, 32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;
        step(2);
        chk_idle_clean("reset");
        reset = 1'b0;
        step();

        scan("w267", 10'h267, 10'h043, 10'h000, 4'd3, 4'd0);
        scan("w00d", 10'h00D, 10'h001, 10'h008, 4'd1, 4'd1);
        scan("w3ff", 10'h3FF, 10'h003, 10'h3F8, 4'd2, 4'd7);
        scan("w000", 10'h000, 10'h000, 10'h000, 4'd0, 4'd0);

        // abort while idle must not disturb anything
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_idle.in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_idle.busy",     32'(bus.busy),     32'd0);

        // Backpressure: in_valid stays high with a second word queued.
        bus.in_word  = 10'h00D;
        bus.in_valid = 1'b1;
        step();
        bus.in_word = 10'h267;
        step(WIDTH);
        for (int c = 0; c < 5; c++) begin
            chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
            chk("bp.hits0",     32'(bus.out_hits0), 32'h001);
            chk("bp.hits1",     32'(bus.out_hits1), 32'h008);
            chk("bp.cnt1",      32'(bus.out_cnt1),  32'd1);
            bus.abort = (c == 2);
            step();
        end
        bus.abort = 1'b0;
        chk("bp.still_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("bp.consumed_valid", 32'(bus.out_valid), 32'd0);
        chk("bp.consumed_ready", 32'(bus.in_ready),  32'd1);
        chk("bp.consumed_busy",  32'(bus.busy),      32'd0);
        step();
        bus.in_valid = 1'b0;
        chk("bp.second_busy", 32'(bus.busy), 32'd1);
        step(WIDTH);
        chk("bp.second_valid", 32'(bus.out_valid), 32'd1);
        chk("bp.second_hits0", 32'(bus.out_hits0), 32'h043);
        chk("bp.second_cnt0",  32'(bus.out_cnt0),  32'd3);
        $display("backpressure second word hits0=0x%03h cnt0=%0d", bus.out_hits0, bus.out_cnt0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Abort once bit_idx has reached 4.
        bus.in_word  = 10'h3FF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(4);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk_idle_clean("abort");
        for (int c = 0; c < 12; c++) begin
            chk("abort.no_valid", 32'(bus.out_valid), 32'd0);
            step();
        end
        $display("abort at bit 4 returned to idle");
        scan("post_abort", 10'h3FF, 10'h003, 10'h3F8, 4'd2, 4'd7);

        // Reset during SHIFT loses the partial result.
        bus.in_word  = 10'h3FF;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step(3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle_clean("mid_reset");
        $display("reset mid-shift returned to idle");
        scan("post_reset", 10'h00D, 10'h001, 10'h008, 4'd1, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
